operand2_sequencer: RTL
=======================

OPERAND2_SEQUENCER -- requirements
Module: operand2_sequencer

Interface
REQ-001 The block SHALL have exactly one clock; reset is asynchronous and active-low: clk (input, 1, rising-edge clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-002 issue_valid  input  1  instruction offered for operand-2 sequencing.
REQ-003 issue_ready  output 1  block can accept an instruction this cycle.
REQ-004 opcode  input  4  instruction opcode, sampled on accept.
REQ-005 dout2  input  16  source-2 register data, sampled on accept.
REQ-006 ext_immed_addr  input  16  sign-extended immediate, sampled on accept.
REQ-007 shift_amm  input  3  shift amount, sampled on accept.
REQ-008 source2_select  output 2  select for the operand-2 mux: 00 register, 01 immediate, 10 shift amount, 11 illegal/none.
REQ-009 op2_data  output 16  registered operand-2 value.
REQ-010 shift_result  output 16  shifted dout2 for SLL/SRL, 0 otherwise.
REQ-011 op2_valid  output 1  op2_data/shift_result valid; held until consumed.
REQ-012 op2_ready  input  1  downstream ALU accepts the operand.
REQ-013 illegal_op  output 1  one-cycle pulse on an undefined opcode.
REQ-014 busy  output 1  high in any state other than IDLE.

Function
REQ-015 Accept occurs when issue_valid && issue_ready are both high on a clk edge; all inputs are captured at that edge.
REQ-016 Decode: 0x0-0x3 gives sel 00 and op2_data=dout2; 0x4-0x7 gives sel 01 and op2_data=ext_immed_addr; 0x8 SLL / 0x9 SRL give sel 10 and op2_data={13'b0,shift_amm}; 0xA-0xF give sel 11 (illegal).
REQ-017 FSM states: IDLE, SHIFT, OUT. IDLE->OUT on a legal non-shift accept or a shift with shift_amm=0; IDLE->SHIFT on a shift with shift_amm>0; SHIFT->OUT when the count reaches 0; OUT->IDLE on op2_ready with no new accept.
REQ-018 In SHIFT, shift_result SHALL shift by one bit per cycle (SLL: left with zero fill, SRL: right logical with zero fill), and a 3-bit down-counter loaded with shift_amm SHALL decrement once per cycle.
REQ-019 Latency: non-shift accept at edge N gives op2_valid high from N+1; a shift of k gives op2_valid high from N+1+k (k=0..7).
REQ-020 op2_valid SHALL be high only in OUT, and op2_data, shift_result and source2_select SHALL stay stable while op2_valid && !op2_ready.
REQ-021 issue_ready = (state==IDLE) || (state==OUT && op2_ready); a simultaneous consume and accept SHALL start the new instruction with no bubble.
REQ-022 An illegal opcode SHALL be accepted, pulse illegal_op at N+1, produce no op2_valid, and leave the FSM in IDLE.
REQ-023 source2_select SHALL hold the decoded value of the current instruction from N+1 until the next accept, and SHALL never be left undriven or latched.
REQ-024 Shift results SHALL be 16 bits; bits shifted out are discarded, and a shift of 7 on 0xFFFF gives 0xFF80 (SLL) or 0x01FF (SRL).

Reset
REQ-025 While rst_n is low: state=IDLE, counter=0, source2_select=2'b00, op2_data=0, shift_result=0, op2_valid=0, illegal_op=0, busy=0; issue_ready is high once rst_n deasserts.
REQ-026 Reset asserted during SHIFT or OUT SHALL abort the instruction immediately, with no op2_valid after release.

Configuration
REQ-027 With OP2_SERIAL_SHIFT_EN defined, shifts SHALL use the serial SHIFT state per REQ-018/019.
REQ-028 Without OP2_SERIAL_SHIFT_EN, the SHIFT state and counter SHALL be absent, shift_result SHALL be computed combinationally at accept, and every legal opcode SHALL have latency 1.

Structure
REQ-029 Shared package op2_pkg SHALL hold the opcode constants, the SEL_REG/SEL_IMM/SEL_SHAMT/SEL_NONE encodings and the state typedef.
REQ-030 The serial shift datapath (register, counter, direction) SHALL be a sub-module op2_serial_shifter, instantiated only when OP2_SERIAL_SHIFT_EN is defined.

Verification
REQ-031 opcode=0x1, dout2=0x1234, op2_ready=1: op2_valid at N+1, op2_data=0x1234, sel=00.
REQ-032 opcode=0x5, ext_immed_addr=0xFFF0, op2_ready held low 3 cycles: data=0xFFF0 and sel=01 stable until release; issue_ready low meanwhile.
REQ-033 opcode=0x8, dout2=0x0001, shift_amm=5 (serial): busy for 5 cycles, op2_valid at N+6, shift_result=0x0020, op2_data=0x0005, sel=10; shift_amm=0 gives N+1.
REQ-034 opcode=0xC: illegal_op pulses once at N+1, no op2_valid, sel=11, next accept possible at N+1.
REQ-035 Back-to-back: second issue_valid during OUT with op2_ready=1: accepted the same cycle, op2_valid continuous across both results.
REQ-036 rst_n pulsed low mid-SHIFT (opcode 0x9, shift_amm=7): all outputs reset values, no op2_valid after release, fresh accept works.

Source files
------------

// File: rtl/operand2_sequencer_pkg.sv
// Shared opcode constants, operand-2 select encodings and FSM state type.
// The SHIFT state only exists when OP2_SERIAL_SHIFT_EN is defined.
package op2_pkg;

    localparam logic [3:0] OP_REG_LAST = 4'h3;
    localparam logic [3:0] OP_IMM_LAST = 4'h7;
    localparam logic [3:0] OP_SLL      = 4'h8;
    localparam logic [3:0] OP_SRL      = 4'h9;

    typedef enum logic [1:0] {
        SEL_REG   = 2'b00,
        SEL_IMM   = 2'b01,
        SEL_SHAMT = 2'b10,
        SEL_NONE  = 2'b11
    } sel_e;

`ifdef OP2_SERIAL_SHIFT_EN
    typedef enum logic [1:0] {StIdle = 2'b00, StShift = 2'b01, StOut = 2'b10} state_e;
`else
    typedef enum logic [1:0] {StIdle = 2'b00, StOut = 2'b10} state_e;
`endif

    function automatic sel_e decode_sel(input logic [3:0] op);
        if (op <= OP_REG_LAST) begin
            return SEL_REG;
        end else if (op <= OP_IMM_LAST) begin
            return SEL_IMM;
        end else if ((op == OP_SLL) || (op == OP_SRL)) begin
            return SEL_SHAMT;
        end
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/operand2_sequencer_if.sv
// Issue-side and ALU-side signals of operand2_sequencer; slave is the sequencer,
// master is whoever issues instructions and consumes operands.
interface operand2_sequencer_if;

    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  opcode;
    logic [15:0] dout2;
    logic [15:0] ext_immed_addr;
    logic [2:0]  shift_amm;
    logic [1:0]  source2_select;
    logic [15:0] op2_data;
    logic [15:0] shift_result;
    logic        op2_valid;
    logic        op2_ready;
    logic        illegal_op;
    logic        busy;

    modport slave (
        input  issue_valid, opcode, dout2, ext_immed_addr, shift_amm, op2_ready,
        output issue_ready, source2_select, op2_data, shift_result, op2_valid, illegal_op, busy
    );

    modport master (
        output issue_valid, opcode, dout2, ext_immed_addr, shift_amm, op2_ready,
        input  issue_ready, source2_select, op2_data, shift_result, op2_valid, illegal_op, busy
    );

endinterface

// File: rtl/operand2_sequencer_shifter.sv
// Serial one-bit-per-cycle shifter with a down-counter; used by operand2_sequencer
// only when OP2_SERIAL_SHIFT_EN is defined.
module op2_serial_shifter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        dir_right_i,
    input  logic [15:0] data_i,
    input  logic [2:0]  amt_i,
    output logic [15:0] result_o,
    output logic        last_o
);

    logic [15:0] data_q, data_d;
    logic [2:0]  count_q, count_d;
    logic        right_q, right_d;

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        right_d = right_q;
        if (load_i) begin
            data_d  = data_i;
            count_d = amt_i;
            right_d = dir_right_i;
        end else if (step_i && (count_q != 3'd0)) begin
            data_d  = right_q ? (data_q >> 1) : (data_q << 1);
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= 16'h0;
            count_q <= 3'd0;
            right_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            right_q <= right_d;
        end
    end

    // The step that takes the count from 1 to 0 is the final one.
    assign last_o   = (count_q == 3'd1);
    assign result_o = data_q;

endmodule

// File: rtl/operand2_sequencer.sv
// Operand-2 sequencer: decodes an issued instruction into a registered operand and
// shift result. Define OP2_SERIAL_SHIFT_EN for serial (multi-cycle) shifts.
module operand2_sequencer
    import op2_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    operand2_sequencer_if.slave bus
);

    state_e      state_q, state_d;
    sel_e        sel_q, sel_d;
    logic [15:0] data_q, data_d;
    logic        illegal_q, illegal_d;

    sel_e        sel_dec;
    logic [15:0] data_dec;
    logic [15:0] shift_result;
    logic        issue_ready;
    logic        accept;
    logic        is_shift;
    logic        shift_right;

    assign sel_dec     = decode_sel(bus.opcode);
    assign is_shift    = (sel_dec == SEL_SHAMT);
    assign shift_right = (bus.opcode == OP_SRL);
    // OUT can hand over to a new instruction in the cycle its result is consumed.
    assign issue_ready = (state_q == StIdle) || ((state_q == StOut) && bus.op2_ready);
    assign accept      = bus.issue_valid && issue_ready;

    always_comb begin
        data_dec = 16'h0;
        case (sel_dec)
            SEL_REG:   data_dec = bus.dout2;
            SEL_IMM:   data_dec = bus.ext_immed_addr;
            SEL_SHAMT: data_dec = {13'b0, bus.shift_amm};
            default:   data_dec = 16'h0;
        endcase
    end

`ifdef OP2_SERIAL_SHIFT_EN
    logic        shift_last;
    logic        start_serial;
    logic [15:0] shift_src;

    assign start_serial = is_shift && (bus.shift_amm != 3'd0);
    assign shift_src    = is_shift ? bus.dout2 : 16'h0;

    op2_serial_shifter u_shifter (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .load_i      (accept),
        .step_i      (state_q == StShift),
        .dir_right_i (shift_right),
        .data_i      (shift_src),
        .amt_i       (bus.shift_amm),
        .result_o    (shift_result),
        .last_o      (shift_last)
    );
`else
    logic [15:0] sres_q, sres_d;

    always_comb begin
        sres_d = sres_q;
        if (accept) begin
            if (!is_shift) begin
                sres_d = 16'h0;
            end else if (shift_right) begin
                sres_d = bus.dout2 >> bus.shift_amm;
            end else begin
                sres_d = bus.dout2 << bus.shift_amm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sres_q <= 16'h0;
        end else begin
            sres_q <= sres_d;
        end
    end

    assign shift_result = sres_q;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        data_d    = data_q;
        illegal_d = 1'b0;
        case (state_q)
`ifdef OP2_SERIAL_SHIFT_EN
            StShift: if (shift_last) state_d = StOut;
`endif
            StOut:   if (bus.op2_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (accept) begin
            sel_d  = sel_dec;
            data_d = data_dec;
            if (sel_dec == SEL_NONE) begin
                illegal_d = 1'b1;
                state_d   = StIdle;
            end
`ifdef OP2_SERIAL_SHIFT_EN
            else if (start_serial) begin
                state_d = StShift;
            end
`endif
            else begin
                state_d = StOut;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sel_q     <= SEL_REG;
            data_q    <= 16'h0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.issue_ready    = issue_ready;
    assign bus.source2_select = sel_q;
    assign bus.op2_data       = data_q;
    assign bus.shift_result   = shift_result;
    assign bus.op2_valid      = (state_q == StOut);
    assign bus.illegal_op     = illegal_q;
    assign bus.busy           = (state_q != StIdle);

endmodule
